// File: rtl/video_in_2_stream_pkg.sv
// Shared definitions for the video capture path: pixel width, FSM states, FIFO entry layout.
package video_in_2_stream_pkg;

  localparam int unsigned PIX_W = 16;

  typedef enum logic [1:0] {
    ST_WAIT_VS = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_DROP    = 2'd2
  } vin_state_t;

  typedef struct packed {
    logic             user;
    logic             last;
    logic [PIX_W-1:0] data;
  } vin_beat_t;

endpackage

// File: rtl/video_in_2_stream_vin_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with full/empty flags.
module vin_sync_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 16
) (
  input  logic             hclk,
  input  logic             hresetn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             rd_ok;
  logic             wr_ok;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  // a pop in the same cycle frees the slot the push needs
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge hclk) begin
    if (wr_ok) mem[wptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rptr[AW-1:0]];

endmodule

// File: rtl/video_in_2_stream.sv
// Parallel RGB565 video to pixel stream with skid register, overflow drop/resync and sticky status.
// Optional line/frame size checker enabled by `VIN_FRAME_CHECK_EN.
module video_in_2_stream
  import video_in_2_stream_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter bit          SYNC_POL   = 1'b1,
  parameter int unsigned H_ACTIVE   = 800,
  parameter int unsigned V_ACTIVE   = 480
) (
  input  logic             hclk,
  input  logic             hresetn,
  input  logic             ce,
  input  logic [PIX_W-1:0] vin_data,
  input  logic             vin_hsync,
  input  logic             vin_vsync,
  input  logic             vin_active,
  output logic [PIX_W-1:0] tdata_m,
  output logic             tlast_m,
  output logic             tuser_m,
  output logic             tvalid_m,
  input  logic             tready_m,
  input  logic             stat_clr,
  output logic             ovf_o,
  output logic             fmt_err_o
);

  vin_state_t       state_q, state_d;
  logic             vs_q, hsync_q;
  logic             skid_vld, skid_user, user_pend;
  logic [PIX_W-1:0] skid_data;
  logic             vs_now, vs_edge;
  logic             push, push_last, cap, ovf_set, ovf_q;
  logic             fifo_full, fifo_empty, pop;
  vin_beat_t        wr_beat, rd_beat;
  logic [PIX_W+1:0] rd_raw;

  assign vs_now  = SYNC_POL ? vin_vsync : !vin_vsync;
  assign vs_edge = ce && vs_now && !vs_q;
  assign pop     = !fifo_empty && tready_m;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state_q <= ST_WAIT_VS;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    push_last = 1'b0;
    ovf_set   = 1'b0;
    cap       = 1'b0;
    if (ce) begin
      case (state_q)
        ST_WAIT_VS: if (vs_edge) state_d = ST_ACTIVE;
        ST_ACTIVE: begin
          // a held pixel closes its line when the new sample is idle or a frame starts
          if (skid_vld) begin
            push      = 1'b1;
            push_last = !vin_active || vs_edge;
            if (fifo_full && !pop) begin
              ovf_set = 1'b1;
              if (!vs_edge) state_d = ST_DROP;
            end
          end
        end
        ST_DROP:    if (vs_edge) state_d = ST_ACTIVE;
        default:    state_d = ST_WAIT_VS;
      endcase
      cap = vin_active && (state_d == ST_ACTIVE);
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      vs_q      <= 1'b0;
      hsync_q   <= 1'b0;
      skid_vld  <= 1'b0;
      skid_user <= 1'b0;
      skid_data <= '0;
      user_pend <= 1'b0;
    end else if (ce) begin
      vs_q     <= vs_now;
      hsync_q  <= vin_hsync;
      skid_vld <= cap;
      if (cap) begin
        skid_data <= vin_data;
        skid_user <= vs_edge || user_pend;
      end
      if (vs_edge)  user_pend <= !cap;
      else if (cap) user_pend <= 1'b0;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)     ovf_q <= 1'b0;
    else if (ovf_set) ovf_q <= 1'b1;
    else if (stat_clr) ovf_q <= 1'b0;
  end

  assign wr_beat = '{user: skid_user, last: push_last, data: skid_data};

  vin_sync_fifo #(
    .WIDTH (PIX_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .hclk    (hclk),
    .hresetn (hresetn),
    .wr_en   (push),
    .wr_data (wr_beat),
    .rd_en   (pop),
    .rd_data (rd_raw),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rd_beat  = rd_raw;
  assign tvalid_m = !fifo_empty;
  assign tdata_m  = fifo_empty ? '0 : rd_beat.data;
  assign tlast_m  = !fifo_empty && rd_beat.last;
  assign tuser_m  = !fifo_empty && rd_beat.user;
  assign ovf_o    = ovf_q;

  logic unused_hsync;
  assign unused_hsync = hsync_q;

`ifdef VIN_FRAME_CHECK_EN
  localparam logic [15:0] H_EXP = 16'(H_ACTIVE);
  localparam logic [15:0] V_EXP = 16'(V_ACTIVE);

  logic [15:0] pix_cnt, line_cnt;
  logic        h_bad, v_bad, fmt_q;

  always_comb begin
    h_bad = push && push_last && ((pix_cnt + 16'd1) != H_EXP);
    v_bad = vs_edge && (state_q == ST_ACTIVE) &&
            ((line_cnt + 16'(push && push_last)) != V_EXP);
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
      fmt_q    <= 1'b0;
    end else begin
      if (vs_edge || (push && push_last)) pix_cnt <= '0;
      else if (push)                      pix_cnt <= pix_cnt + 16'd1;
      if (vs_edge)                        line_cnt <= '0;
      else if (push && push_last)         line_cnt <= line_cnt + 16'd1;
      if (h_bad || v_bad)                 fmt_q <= 1'b1;
      else if (stat_clr)                  fmt_q <= 1'b0;
    end
  end

  assign fmt_err_o = fmt_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(H_ACTIVE), 32'(V_ACTIVE)};
  assign fmt_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_video_in_2_stream.sv
// Randomized bench for video_in_2_stream: frames are described as pixel lists and compared beat by beat.
module tb_video_in_2_stream;

`ifdef VIN_FRAME_CHECK_EN
  localparam int unsigned H_EXP  = 4;
  localparam int unsigned V_EXP  = 2;
  localparam logic        FMT_ON = 1'b1;
`else
  localparam int unsigned H_EXP  = 800;
  localparam int unsigned V_EXP  = 480;
  localparam logic        FMT_ON = 1'b0;
`endif
  localparam int unsigned DEPTH = 16;

  typedef struct packed {
    logic        user;
    logic        last;
    logic [15:0] data;
  } beat_t;

  logic        hclk = 1'b0;
  logic        hresetn, ce, vin_hsync, vin_vsync, vin_vsync_n, vin_active, tready_m, stat_clr;
  logic [15:0] vin_data;
  logic [15:0] tdata_m, tdata_n;
  logic        tlast_m, tuser_m, tvalid_m, ovf_o, fmt_err_o;
  logic        tlast_n, tuser_n, tvalid_n, ovf_n, fmt_err_n;

  assign vin_vsync_n = ~vin_vsync;
  always #5 hclk = ~hclk;

  video_in_2_stream #(
    .FIFO_DEPTH (DEPTH), .SYNC_POL (1'b1), .H_ACTIVE (H_EXP), .V_ACTIVE (V_EXP)
  ) dut (
    .hclk (hclk), .hresetn (hresetn), .ce (ce), .vin_data (vin_data),
    .vin_hsync (vin_hsync), .vin_vsync (vin_vsync), .vin_active (vin_active),
    .tdata_m (tdata_m), .tlast_m (tlast_m), .tuser_m (tuser_m), .tvalid_m (tvalid_m),
    .tready_m (tready_m), .stat_clr (stat_clr), .ovf_o (ovf_o), .fmt_err_o (fmt_err_o)
  );

  video_in_2_stream #(
    .FIFO_DEPTH (DEPTH), .SYNC_POL (1'b0), .H_ACTIVE (H_EXP), .V_ACTIVE (V_EXP)
  ) dut_n (
    .hclk (hclk), .hresetn (hresetn), .ce (ce), .vin_data (vin_data),
    .vin_hsync (vin_hsync), .vin_vsync (vin_vsync_n), .vin_active (vin_active),
    .tdata_m (tdata_n), .tlast_m (tlast_n), .tuser_m (tuser_n), .tvalid_m (tvalid_n),
    .tready_m (tready_m), .stat_clr (stat_clr), .ovf_o (ovf_n), .fmt_err_o (fmt_err_n)
  );

  int    n_checks = 0;
  int    n_errors = 0;
  beat_t q[$];
  beat_t qn[$];
  bit    model_en = 1'b1;
  bit    ce_tog   = 1'b0;
  bit    rand_rdy = 1'b0;
  int unsigned lim    = 32'hffff_ffff;
  int unsigned pushed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one ce-qualified sample; in toggle mode a ce=0 cycle of junk precedes it
  task automatic smp(input logic vs, input logic act, input logic [15:0] d);
    if (ce_tog) begin
      ce         = 1'b0;
      vin_vsync  = 1'($urandom);
      vin_active = 1'($urandom);
      vin_data   = 16'($urandom);
      @(posedge hclk); #1;
    end
    ce         = 1'b1;
    vin_vsync  = vs;
    vin_active = act;
    vin_data   = d;
    vin_hsync  = 1'($urandom);
    @(posedge hclk); #1;
  endtask

  task automatic expect_pix(input beat_t b);
    if (model_en && pushed < lim) begin
      q.push_back(b);
      qn.push_back(b);
    end
    pushed++;
  endtask

  task automatic send_frame(input int unsigned w, input int unsigned h, input int unsigned gap);
    logic [15:0] d;
    pushed = 0;
    smp(1'b1, 1'b0, 16'h0);
    smp(1'b1, 1'b0, 16'h0);
    smp(1'b0, 1'b0, 16'h0);
    for (int unsigned y = 0; y < h; y++) begin
      for (int unsigned x = 0; x < w; x++) begin
        d = 16'($urandom);
        expect_pix('{user: (x == 0 && y == 0), last: (x == w - 1), data: d});
        smp(1'b0, 1'b1, d);
      end
      for (int unsigned g = 0; g < gap; g++) smp(1'b0, 1'b0, 16'($urandom));
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400; i++) begin
      if (q.size() == 0 && qn.size() == 0) break;
      @(posedge hclk); #1;
    end
    check({tag, "_drain"}, 32'(q.size() + qn.size()), 32'd0);
  endtask

  task automatic pulse_clr();
    stat_clr = 1'b1;
    @(posedge hclk); #1;
    stat_clr = 1'b0;
  endtask

  beat_t mb, mbn, held_b;
  logic  held_v = 1'b0;

  always @(negedge hclk) begin
    if (hresetn && tvalid_m && tready_m) begin
      if (q.size() == 0) check("extra_beat", {14'h0, tuser_m, tlast_m, tdata_m}, 32'hdead_beef);
      else begin
        mb = q.pop_front();
        check("beat", {14'h0, tuser_m, tlast_m, tdata_m}, {14'h0, mb});
      end
    end
  end

  always @(negedge hclk) begin
    if (hresetn && tvalid_n && tready_m) begin
      if (qn.size() == 0) check("extra_beat_n", {14'h0, tuser_n, tlast_n, tdata_n}, 32'hdead_beef);
      else begin
        mbn = qn.pop_front();
        check("beat_n", {14'h0, tuser_n, tlast_n, tdata_n}, {14'h0, mbn});
      end
    end
  end

  always @(negedge hclk) begin
    if (hresetn && held_v) check("stable", {14'h0, tuser_m, tlast_m, tdata_m}, {14'h0, held_b});
    held_v <= hresetn && tvalid_m && !tready_m;
    held_b <= '{user: tuser_m, last: tlast_m, data: tdata_m};
  end

  initial begin
    forever begin
      @(posedge hclk); #1;
      if (rand_rdy) tready_m = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    hresetn = 1'b0; ce = 1'b0; vin_hsync = 1'b0; vin_vsync = 1'b0; vin_active = 1'b0;
    vin_data = '0; tready_m = 1'b1; stat_clr = 1'b0;
    repeat (3) @(posedge hclk);
    #1;
    check("rst_tvalid", 32'(tvalid_m), 32'd0);
    check("rst_tdata", 32'(tdata_m), 32'd0);
    check("rst_flags", {30'h0, tlast_m, tuser_m}, 32'd0);
    check("rst_ovf", 32'(ovf_o), 32'd0);
    check("rst_fmt", 32'(fmt_err_o), 32'd0);
    check("rst_tvalid_n", 32'(tvalid_n), 32'd0);
    hresetn = 1'b1;
    ce      = 1'b1;
    repeat (2) @(posedge hclk);
    #1;

    send_frame(4, 3, 2);
    wait_drain("basic");
    check("basic_idle", 32'(tvalid_m), 32'd0);

    rand_rdy = 1'b1;
    for (int f = 0; f < 8; f++) begin
      send_frame($urandom_range(1, 5), $urandom_range(1, 3), $urandom_range(1, 3));
      wait_drain("rand");
    end
    rand_rdy = 1'b0;
    @(posedge hclk); #1;
    tready_m = 1'b1;
    check("rand_no_ovf", {30'h0, ovf_o, ovf_n}, 32'd0);

    ce_tog = 1'b1;
    send_frame(2, 1, 2);
    ce_tog = 1'b0;
    wait_drain("ce_tog");

    tready_m = 1'b0;
    lim      = DEPTH;
    send_frame(8, 4, 1);
    repeat (4) smp(1'b0, 1'b0, 16'h0);
    check("ovf_full_valid", 32'(tvalid_m), 32'd1);
    check("ovf_set", {30'h0, ovf_o, ovf_n}, 32'd3);
    check("ovf_q_len", 32'(q.size()), DEPTH);
    tready_m = 1'b1;
    wait_drain("ovf");
    lim = 32'hffff_ffff;
    send_frame(4, 3, 1);
    wait_drain("resync");
    check("ovf_sticky", 32'(ovf_o), 32'd1);
    pulse_clr();
    check("ovf_clr", {30'h0, ovf_o, ovf_n}, 32'd0);

    tready_m = 1'b0;
    model_en = 1'b0;
    smp(1'b1, 1'b0, 16'h0);
    smp(1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 6; i++) smp(1'b0, 1'b1, 16'($urandom));
    hresetn = 1'b0;
    #1;
    check("midrst_tvalid", {30'h0, tvalid_m, tvalid_n}, 32'd0);
    repeat (2) @(posedge hclk);
    #1;
    hresetn  = 1'b1;
    tready_m = 1'b1;
    for (int i = 0; i < 6; i++) smp(1'b0, 1'b1, 16'($urandom));
    for (int i = 0; i < 3; i++) smp(1'b0, 1'b0, 16'h0);
    check("midrst_silent", {30'h0, tvalid_m, tvalid_n}, 32'd0);
    model_en = 1'b1;
    send_frame(3, 2, 1);
    wait_drain("post_rst");

    send_frame(4, 2, 1);
    wait_drain("fmt_a");
    pulse_clr();
    check("fmt_clr0", {30'h0, fmt_err_o, fmt_err_n}, 32'd0);
    send_frame(4, 2, 1);
    wait_drain("fmt_b");
    check("fmt_good", {30'h0, fmt_err_o, fmt_err_n}, 32'd0);
    send_frame(3, 2, 1);
    wait_drain("fmt_c");
    check("fmt_short_line", {30'h0, fmt_err_o, fmt_err_n}, {30'h0, FMT_ON, FMT_ON});
    pulse_clr();
    check("fmt_clr1", {30'h0, fmt_err_o, fmt_err_n}, 32'd0);

    repeat (3) @(posedge hclk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
